// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: turns level read/write requests into timed chip cycles.
// Optional per-byte lane enables are compiled in with `define SRAM_BYTE_LANE_EN.
module sram_ctrl #(
  parameter int READ_CYCLES     = 2,
  parameter int WR_SETUP_CYCLES = 1,
  parameter int WR_PULSE_CYCLES = 2,
  parameter int WR_HOLD_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] addr_i,
  inout  wire  [15:0] data_io,
  input  logic        re_i,
  input  logic        we_i,
`ifdef SRAM_BYTE_LANE_EN
  input  logic [1:0]  be_i,
`endif
  output logic        needWait_o,
  output logic [17:0] sram_addr_o,
  inout  wire  [15:0] sram_dq_io,
  output logic        sram_ce_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_we_n_o,
  output logic        sram_ub_n_o,
  output logic        sram_lb_n_o
);

  typedef enum logic [2:0] {IDLE, READ, WSETUP, WPULSE, WHOLD, DONE} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [17:0] addr_reg, addr_next;
  logic [15:0] wdata_reg, wdata_next;
  logic [15:0] rdata_reg;
  logic [1:0]  be_reg, be_next;
  logic        rd_acc_reg, rd_acc_next;
  logic        capture;
  logic        active_next;
  logic [1:0]  lane_req;

  logic        ce_n_reg, oe_n_reg, we_n_reg, ub_n_reg, lb_n_reg;
  logic        dq_oe_reg;
  logic [15:0] dq_out_reg;

`ifdef SRAM_BYTE_LANE_EN
  assign lane_req = be_i;
`else
  assign lane_req = 2'b11;
`endif

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    be_next     = be_reg;
    rd_acc_next = rd_acc_reg;
    capture     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (we_i) begin
          addr_next   = addr_i;
          wdata_next  = data_io;
          be_next     = lane_req;
          rd_acc_next = 1'b0;
          cnt_next    = 4'(WR_SETUP_CYCLES - 1);
          state_next  = WSETUP;
        end else if (re_i) begin
          addr_next   = addr_i;
          be_next     = lane_req;
          rd_acc_next = 1'b1;
          cnt_next    = 4'(READ_CYCLES - 1);
          state_next  = READ;
        end
      end
      READ: begin
        if (cnt_reg == 4'd0) begin
          capture    = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      WSETUP: begin
        if (cnt_reg == 4'd0) begin
          cnt_next   = 4'(WR_PULSE_CYCLES - 1);
          state_next = WPULSE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      WPULSE: begin
        if (cnt_reg == 4'd0) begin
          cnt_next   = 4'(WR_HOLD_CYCLES - 1);
          state_next = WHOLD;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      WHOLD: begin
        if (cnt_reg == 4'd0) state_next = DONE;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pin registers are loaded from the next state so they line up with the state they belong to.
  assign active_next = (state_next == READ) || (state_next == WSETUP) ||
                       (state_next == WPULSE) || (state_next == WHOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      addr_reg   <= 18'd0;
      wdata_reg  <= 16'd0;
      rdata_reg  <= 16'd0;
      be_reg     <= 2'b00;
      rd_acc_reg <= 1'b0;
      ce_n_reg   <= 1'b1;
      oe_n_reg   <= 1'b1;
      we_n_reg   <= 1'b1;
      ub_n_reg   <= 1'b1;
      lb_n_reg   <= 1'b1;
      dq_oe_reg  <= 1'b0;
      dq_out_reg <= 16'd0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      be_reg     <= be_next;
      rd_acc_reg <= rd_acc_next;
      if (capture) rdata_reg <= sram_dq_io;
      ce_n_reg   <= ~active_next;
      oe_n_reg   <= ~(state_next == READ);
      we_n_reg   <= ~(state_next == WPULSE);
      ub_n_reg   <= ~(active_next & be_next[1]);
      lb_n_reg   <= ~(active_next & be_next[0]);
      dq_oe_reg  <= (state_next == WSETUP) || (state_next == WPULSE) || (state_next == WHOLD);
      dq_out_reg <= wdata_next;
    end
  end

  assign needWait_o  = (re_i | we_i) & (state_reg != DONE);
  assign sram_addr_o = addr_reg;
  assign sram_ce_n_o = ce_n_reg;
  assign sram_oe_n_o = oe_n_reg;
  assign sram_we_n_o = we_n_reg;
  assign sram_ub_n_o = ub_n_reg;
  assign sram_lb_n_o = lb_n_reg;

  // Only a completed read returns data, so a combined re/we (executed as a write) never drives the CPU bus.
  assign data_io    = (state_reg == DONE && re_i && rd_acc_reg) ? rdata_reg : 16'hzzzz;
  assign sram_dq_io = dq_oe_reg ? dq_out_reg : 16'hzzzz;

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized scoreboard bench for sram_ctrl with a behavioural SRAM chip and reference memory.
// A second instance covers a non-default timing configuration.
module tb_sram_ctrl;
  localparam int RC = 2, WS = 1, WP = 2, WH = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- main instance ----------------
  logic [17:0] addr_i = '0;
  logic        re_i = 1'b0, we_i = 1'b0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_drv = 1'b0;
  logic [1:0]  be_i = 2'b11;
  wire  [15:0] data_io;
  wire  [15:0] sram_dq_io;
  logic [17:0] sram_addr_o;
  logic        need_wait, ce_n, oe_n, we_n, ub_n, lb_n;

  assign data_io = cpu_drv ? cpu_wdata : 16'hzzzz;

  sram_ctrl #(.READ_CYCLES(RC), .WR_SETUP_CYCLES(WS), .WR_PULSE_CYCLES(WP), .WR_HOLD_CYCLES(WH)) u_dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .data_io(data_io), .re_i(re_i), .we_i(we_i),
`ifdef SRAM_BYTE_LANE_EN
    .be_i(be_i),
`endif
    .needWait_o(need_wait), .sram_addr_o(sram_addr_o), .sram_dq_io(sram_dq_io),
    .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n), .sram_we_n_o(we_n), .sram_ub_n_o(ub_n), .sram_lb_n_o(lb_n)
  );

  // Behavioural asynchronous SRAM chip
  logic [15:0] chip_mem [0:262143];
  logic [15:0] ref_mem  [0:262143];
  logic [15:0] chip_q;
  assign chip_q     = chip_mem[sram_addr_o];
  assign sram_dq_io = (!ce_n && !oe_n && we_n) ? chip_q : 16'hzzzz;
  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      if (!ub_n) chip_mem[sram_addr_o][15:8] <= sram_dq_io[15:8];
      if (!lb_n) chip_mem[sram_addr_o][7:0]  <= sram_dq_io[7:0];
    end
  end

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] be);
    return {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          is_wr;
    logic [17:0] addr;
    logic [15:0] data;
    int          issue;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  // current access, used by the pin-timing checker
  bit          cur_active = 1'b0;
  bit          cur_wr = 1'b0;
  int          cur_issue = 0;
  logic [17:0] cur_addr = '0;
  logic [15:0] cur_wdata = '0;
  logic [1:0]  cur_be = 2'b11;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (re_i || we_i) && !need_wait) begin
      if (sb_q.size() == 0) begin
        check(1'b0, "unexpected_done", 64'(cyc), 64'(0));
      end else begin
        e = sb_q.pop_front();
        check(cyc - e.issue == e.lat, e.is_wr ? "wr_latency" : "rd_latency", 64'(cyc - e.issue), 64'(e.lat));
        if (e.is_wr) begin
          check(chip_mem[e.addr] == e.data, "wr_chip_data", 64'(chip_mem[e.addr]), 64'(e.data));
          check(data_io === 16'hzzzz || data_io === 16'h0000, "wr_data_io_idle", 64'(data_io), 64'(0));
        end else begin
          check(data_io == e.data, "rd_data", 64'(data_io), 64'(e.data));
        end
      end
    end
  end

  // Pin timing derived from cycle offsets within the access
  always @(negedge clk) begin
    int rel;
    bit ce_e, oe_e, we_e, dq_e;
    logic [38:0] act, exp;
    if (cur_active && !rst) begin
      rel = cyc - cur_issue;
      if (cur_wr) begin
        ce_e = (rel >= 1) && (rel <= WS + WP + WH);
        we_e = (rel >= 1 + WS) && (rel <= WS + WP);
        oe_e = 1'b0;
        dq_e = ce_e;
      end else begin
        ce_e = (rel >= 1) && (rel <= RC);
        oe_e = ce_e;
        we_e = 1'b0;
        dq_e = 1'b0;
      end
      act = {ce_n, oe_n, we_n, ub_n, lb_n, dq_e ? sram_dq_io : 16'h0, (rel != 0) ? sram_addr_o : 18'h0};
      exp = {!ce_e, !oe_e, !we_e, !(ce_e && cur_be[1]), !(ce_e && cur_be[0]),
             dq_e ? cur_wdata : 16'h0, (rel != 0) ? cur_addr : 18'h0};
      check(act == exp, "pins", 64'(act), 64'(exp));
    end
  end

  // Issue one access from an IDLE cycle (called at posedge+1); returns at posedge+1 of the cycle after DONE.
  task automatic access(input bit re, input bit we, input logic [17:0] a, input logic [15:0] d, input logic [1:0] be);
    exp_t e;
    bit done = 1'b0;
    e.is_wr = we;
    e.addr  = a;
    e.issue = cyc;
    e.lat   = we ? 1 + WS + WP + WH : 1 + RC;
    if (we) ref_mem[a] = merge(ref_mem[a], d, be);
    e.data = ref_mem[a];
    sb_q.push_back(e);
    cur_wr = we; cur_issue = cyc; cur_addr = a; cur_wdata = d; cur_be = be; cur_active = 1'b1;
    re_i = re; we_i = we; addr_i = a; cpu_wdata = d; cpu_drv = we; be_i = be;
    @(posedge clk); #1;
    cpu_drv = 1'b0;  // the controller latched the write data on acceptance
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (!need_wait) begin done = 1'b1; break; end
    end
    if (!done) check(1'b0, "access_timeout", 64'(cyc), 64'(e.issue + e.lat));
    @(posedge clk); #1;
    cur_active = 1'b0;
    re_i = 1'b0; we_i = 1'b0;
  endtask

  // ---------------- sweep instance ----------------
  logic        re2 = 1'b0, we2 = 1'b0, drv2 = 1'b0;
  logic [1:0]  be2 = 2'b11;
  wire  [15:0] data2_io, dq2_io;
  logic [17:0] addr2_o;
  logic        nw2, ce2_n, oe2_n, we2_n, ub2_n, lb2_n;
  assign data2_io = drv2 ? 16'h0F0F : 16'hzzzz;

  sram_ctrl #(.READ_CYCLES(1), .WR_SETUP_CYCLES(1), .WR_PULSE_CYCLES(5), .WR_HOLD_CYCLES(1)) u_dut2 (
    .clk(clk), .rst(rst), .addr_i(18'h00042), .data_io(data2_io), .re_i(re2), .we_i(we2),
`ifdef SRAM_BYTE_LANE_EN
    .be_i(be2),
`endif
    .needWait_o(nw2), .sram_addr_o(addr2_o), .sram_dq_io(dq2_io),
    .sram_ce_n_o(ce2_n), .sram_oe_n_o(oe2_n), .sram_we_n_o(we2_n), .sram_ub_n_o(ub2_n), .sram_lb_n_o(lb2_n)
  );

  // ---------------- stimulus ----------------
  logic [17:0] pool [8];

  initial begin
    int n, low;
    bit r, w;
    logic [1:0] be;
    for (int i = 0; i < 262144; i++) begin
      chip_mem[i] = 16'(i) ^ 16'hC3A5;
      ref_mem[i]  = 16'(i) ^ 16'hC3A5;
    end
    for (int i = 0; i < 8; i++) pool[i] = 18'($urandom_range(0, 262143));

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({ce_n, oe_n, we_n, ub_n, lb_n} == 5'b11111, "reset_ctrl", 64'({ce_n, oe_n, we_n, ub_n, lb_n}), 64'h1F);
    check(sram_addr_o == 18'h0, "reset_addr", 64'(sram_addr_o), 64'h0);
    check(need_wait == 1'b0, "reset_wait", 64'(need_wait), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // directed: read, write, read-back, simultaneous request
    chip_mem[18'h12345] = 16'hBEEF;
    ref_mem[18'h12345]  = 16'hBEEF;
    access(1'b1, 1'b0, 18'h12345, 16'h0000, 2'b11);
    access(1'b0, 1'b1, 18'h3FFFF, 16'hA55A, 2'b11);
    access(1'b1, 1'b0, 18'h3FFFF, 16'h0000, 2'b11);
    access(1'b1, 1'b1, 18'h00100, 16'h1357, 2'b11);
    access(1'b1, 1'b0, 18'h00100, 16'h0000, 2'b11);

`ifdef SRAM_BYTE_LANE_EN
    chip_mem[18'h00200] = 16'hFFFF;
    ref_mem[18'h00200]  = 16'hFFFF;
    access(1'b0, 1'b1, 18'h00200, 16'h1234, 2'b10);
    access(1'b1, 1'b0, 18'h00200, 16'h0000, 2'b11);
    check(ref_mem[18'h00200] == 16'h12FF, "byte_lane_model", 64'(ref_mem[18'h00200]), 64'h12FF);
`endif

    // reset in the middle of the write pulse
    we_i = 1'b1; addr_i = 18'h00300; cpu_wdata = 16'h7E57; cpu_drv = 1'b1;
    @(posedge clk); #1; cpu_drv = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check(we_n == 1'b0, "mid_wpulse", 64'(we_n), 64'h0);
    @(posedge clk); #1;
    rst = 1'b1; we_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({ce_n, oe_n, we_n} == 3'b111, "rst_mid_ctrl", 64'({ce_n, oe_n, we_n}), 64'h7);
    check(need_wait == 1'b0, "rst_mid_wait", 64'(need_wait), 64'h0);
    check(sram_dq_io === 16'hzzzz || sram_dq_io === 16'h0000, "rst_mid_dq", 64'(sram_dq_io), 64'h0);
    check(sram_addr_o == 18'h0, "rst_mid_addr", 64'(sram_addr_o), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    ref_mem[18'h00300] = 16'h7E57;  // WE was low for full cycles with data on the bus
    @(posedge clk); #1;
    access(1'b1, 1'b0, 18'h00300, 16'h0000, 2'b11);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if (!r && !w) r = 1'b1;
`ifdef SRAM_BYTE_LANE_EN
      be = 2'($urandom_range(0, 3));
`else
      be = 2'b11;
`endif
      access(r, w, pool[$urandom_range(0, 7)], 16'($urandom), be);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    check(sb_q.size() == 0, "sb_drain", 64'(sb_q.size()), 64'h0);

    // timing sweep: READ_CYCLES=1, WR_PULSE_CYCLES=5
    re2 = 1'b1;
    n = 0;
    while (n < 40) begin @(negedge clk); if (!nw2) break; n++; end
    check(n == 2, "sweep_rd_latency", 64'(n), 64'd2);
    @(posedge clk); #1; re2 = 1'b0;
    @(posedge clk); #1;
    we2 = 1'b1; drv2 = 1'b1;
    n = 0; low = 0;
    while (n < 40) begin
      @(negedge clk);
      if (!we2_n) low++;
      if (!nw2) break;
      n++;
    end
    check(low == 5, "sweep_we_low", 64'(low), 64'd5);
    check(n == 8, "sweep_wr_latency", 64'(n), 64'd8);
    @(posedge clk); #1; we2 = 1'b0; drv2 = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
